// File: rtl/rx_pilot_extractor_wifi_if.sv
// -----------------------------------------------------------------------------
// rx_pilot_extractor_wifi_if
// Stream bundle between the FFT output and the equaliser/demapper side of the
// WIFI receive pilot extractor.
//
// Signals
//   frame_start          packet start pulse (reseeds pilot polarity)
//   in_valid / in_first  input subcarrier strobe / first-subcarrier marker
//   in_i / in_q          received subcarrier, signed W bits
//   out_valid / out_last data subcarrier strobe / 48th data subcarrier
//   out_i / out_q        forwarded data subcarrier, signed W bits
//   pilot_valid          pilot sums ready pulse
//   pilot_sum_i/_q       polarity-corrected pilot sums, signed W+3 bits
//   sym_index            symbol number (mod 127) of the sums
//   sym_err              pulse: symbol aborted by an early in_first
//
// Modports
//   master  sample source / result sink (drives the inputs)
//   slave   the extractor itself
// -----------------------------------------------------------------------------
interface rx_pilot_extractor_wifi_if #(
    parameter int W = 12
) ();

    logic                frame_start;
    logic                in_valid;
    logic                in_first;
    logic signed [W-1:0] in_i;
    logic signed [W-1:0] in_q;

    logic                out_valid;
    logic signed [W-1:0] out_i;
    logic signed [W-1:0] out_q;
    logic                out_last;

    logic                pilot_valid;
    logic signed [W+2:0] pilot_sum_i;
    logic signed [W+2:0] pilot_sum_q;
    logic [6:0]          sym_index;
    logic                sym_err;

    modport master (
        output frame_start, in_valid, in_first, in_i, in_q,
        input  out_valid, out_i, out_q, out_last,
        input  pilot_valid, pilot_sum_i, pilot_sum_q, sym_index, sym_err
    );

    modport slave (
        input  frame_start, in_valid, in_first, in_i, in_q,
        output out_valid, out_i, out_q, out_last,
        output pilot_valid, pilot_sum_i, pilot_sum_q, sym_index, sym_err
    );

endinterface

// File: rtl/rx_pilot_extractor_wifi.sv
// -----------------------------------------------------------------------------
// rx_pilot_extractor_wifi
// Receive-side pilot handling for the WIFI PHY, placed after the FFT and before
// the equaliser/demapper. Each OFDM symbol carries 52 used subcarriers
// (idx 0..51 = k -26..-1, +1..+26). The 48 data subcarriers are forwarded
// unchanged with one cycle of latency; the 4 pilots (idx 5,19,32,46) are
// stripped, multiplied by the expected polarity p_n * base and summed for
// common-phase-error tracking. p_n comes from the 127-period scrambler LFSR
// regenerated locally.
//
// Ports
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    rx_pilot_extractor_wifi_if.slave (sample stream in, data and
//          pilot results out)
// -----------------------------------------------------------------------------
module rx_pilot_extractor_wifi #(
    parameter int W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    rx_pilot_extractor_wifi_if.slave bus
);

    localparam int         ACC_W     = W + 3;
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam logic [5:0] LAST_IDX  = 6'd51;
    localparam logic [5:0] NEG_PILOT = 6'd46;   // pilot with base pattern -1
    localparam logic [6:0] LAST_SYM  = 7'd126;

    // Pilot positions within the 52 used subcarriers.
    function automatic logic is_pilot(input logic [5:0] idx);
        return (idx == 6'd5) || (idx == 6'd19) || (idx == 6'd32) || (idx == 6'd46);
    endfunction

    // Sign-extend to the accumulator width before negating so that the most
    // negative sample negates exactly and never saturates.
    function automatic logic signed [ACC_W-1:0] signed_term(
        input logic signed [W-1:0] smp,
        input logic                neg
    );
        logic signed [ACC_W-1:0] ext;
        ext = {{3{smp[W-1]}}, smp};
        return neg ? -ext : ext;
    endfunction

    // Symbol tracking state
    logic [5:0]              idx;
    logic [6:0]              lfsr;
    logic [6:0]              sym_cnt;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;

    // Output stage registers
    logic                    vld_p1;
    logic signed [W-1:0]     data_i_p1;
    logic signed [W-1:0]     data_q_p1;
    logic                    last_p1;
    logic                    pvld_p1;
    logic signed [ACC_W-1:0] psum_i_p1;
    logic signed [ACC_W-1:0] psum_q_p1;
    logic [6:0]              sym_idx_p1;
    logic                    err_p1;

    // Effective state after frame_start / in_first overrides for this cycle
    logic                    restart;
    logic                    abort;
    logic                    acc_clr;
    logic [5:0]              idx_eff;
    logic [6:0]              lfsr_eff;
    logic [6:0]              cnt_eff;
    logic signed [ACC_W-1:0] acc_i_eff;
    logic signed [ACC_W-1:0] acc_q_eff;
    logic                    pol_neg;
    logic                    pilot_neg;
    logic                    pilot_hit;
    logic                    data_hit;
    logic                    sym_end;
    logic signed [ACC_W-1:0] acc_i_nxt;
    logic signed [ACC_W-1:0] acc_q_nxt;
    logic [6:0]              cnt_nxt;

    // frame_start takes priority: a sample arriving with it is already idx 0 of
    // symbol 0 with a reseeded LFSR. An early in_first restarts the symbol
    // position only; LFSR and symbol count stay put so the retried symbol
    // reuses the same polarity.
    always_comb begin
        restart   = bus.frame_start | (bus.in_valid & bus.in_first);
        abort     = bus.in_valid & bus.in_first & ~bus.frame_start & (idx != 6'd0);
        acc_clr   = bus.frame_start | abort;
        idx_eff   = restart ? 6'd0 : idx;
        lfsr_eff  = bus.frame_start ? LFSR_SEED : lfsr;
        cnt_eff   = bus.frame_start ? 7'd0 : sym_cnt;
        acc_i_eff = acc_clr ? '0 : acc_i;
        acc_q_eff = acc_clr ? '0 : acc_q;

        pol_neg   = lfsr_eff[6] ^ lfsr_eff[3];
        pilot_neg = pol_neg ^ (idx_eff == NEG_PILOT);

        pilot_hit = bus.in_valid & is_pilot(idx_eff);
        data_hit  = bus.in_valid & ~is_pilot(idx_eff);
        sym_end   = bus.in_valid & (idx_eff == LAST_IDX);

        acc_i_nxt = acc_i_eff;
        acc_q_nxt = acc_q_eff;
        if (pilot_hit) begin
            acc_i_nxt = acc_i_eff + signed_term(bus.in_i, pilot_neg);
            acc_q_nxt = acc_q_eff + signed_term(bus.in_q, pilot_neg);
        end

        cnt_nxt = (cnt_eff == LAST_SYM) ? 7'd0 : cnt_eff + 7'd1;
    end

    // Symbol state update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= 6'd0;
            lfsr    <= LFSR_SEED;
            sym_cnt <= 7'd0;
            acc_i   <= '0;
            acc_q   <= '0;
        end else begin
            idx     <= idx_eff;
            lfsr    <= lfsr_eff;
            sym_cnt <= cnt_eff;
            acc_i   <= acc_i_eff;
            acc_q   <= acc_q_eff;
            if (sym_end) begin
                idx     <= 6'd0;
                lfsr    <= {lfsr_eff[5:0], pol_neg};
                sym_cnt <= cnt_nxt;
                acc_i   <= '0;
                acc_q   <= '0;
            end else if (bus.in_valid) begin
                idx   <= idx_eff + 6'd1;
                acc_i <= acc_i_nxt;
                acc_q <= acc_q_nxt;
            end
        end
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            data_i_p1  <= '0;
            data_q_p1  <= '0;
            last_p1    <= 1'b0;
            pvld_p1    <= 1'b0;
            psum_i_p1  <= '0;
            psum_q_p1  <= '0;
            sym_idx_p1 <= 7'd0;
            err_p1     <= 1'b0;
        end else begin
            vld_p1  <= data_hit;
            last_p1 <= sym_end;
            pvld_p1 <= sym_end;
            err_p1  <= abort;
            if (data_hit) begin
                data_i_p1 <= bus.in_i;
                data_q_p1 <= bus.in_q;
            end
            // Sums and index hold between symbol ends.
            if (sym_end) begin
                psum_i_p1  <= acc_i_nxt;
                psum_q_p1  <= acc_q_nxt;
                sym_idx_p1 <= cnt_eff;
            end
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_i       = data_i_p1;
    assign bus.out_q       = data_q_p1;
    assign bus.out_last    = last_p1;
    assign bus.pilot_valid = pvld_p1;
    assign bus.pilot_sum_i = psum_i_p1;
    assign bus.pilot_sum_q = psum_q_p1;
    assign bus.sym_index   = sym_idx_p1;
    assign bus.sym_err     = err_p1;

endmodule

// File: tb/tb_rx_pilot_extractor_wifi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rx_pilot_extractor_wifi
// Directed bench for rx_pilot_extractor_wifi: drives symbols of 52 subcarriers
// through the interface and checks forwarded data, pilot sums, symbol index and
// abort pulses against values built here.
// -----------------------------------------------------------------------------
module tb_rx_pilot_extractor_wifi;

    localparam int W = 12;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rx_pilot_extractor_wifi_if #(.W(W)) bus ();

    rx_pilot_extractor_wifi #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Captured outputs (written only by the monitor)
    int got_i[$];
    int got_q[$];
    int got_last[$];
    int ev_i[$];
    int ev_q[$];
    int ev_idx[$];
    int err_pulses = 0;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            got_i.push_back(int'(bus.out_i));
            got_q.push_back(int'(bus.out_q));
            got_last.push_back(int'(bus.out_last));
        end
        if (bus.pilot_valid) begin
            ev_i.push_back(int'(bus.pilot_sum_i));
            ev_q.push_back(int'(bus.pilot_sum_q));
            ev_idx.push_back(int'(bus.sym_index));
        end
        if (bus.sym_err) err_pulses++;
    end

    // Expected data and pilot values (written only by the stimulus process)
    int exp_i[$];
    int exp_q[$];
    int pil_i[4];
    int pil_q[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic int pilot_slot(input int idx);
        case (idx)
            5:       return 0;
            19:      return 1;
            32:      return 2;
            46:      return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int base_of(input int slot);
        return (slot == 3) ? -1 : 1;
    endfunction

    // Polarity p_n of symbol n from the x^7+x^4+1 scrambler seeded all-ones.
    function automatic int pn(input int n);
        logic [6:0] s;
        logic       b;
        s = 7'h7F;
        for (int k = 0; k < n; k++) begin
            b = s[6] ^ s[3];
            s = {s[5:0], b};
        end
        return (s[6] ^ s[3]) ? -1 : 1;
    endfunction

    task automatic cycle(input logic v, input logic first, input logic fs,
                         input logic signed [W-1:0] i, input logic signed [W-1:0] q);
        @(negedge clk);
        bus.in_valid    = v;
        bus.in_first    = first;
        bus.frame_start = fs;
        bus.in_i        = i;
        bus.in_q        = q;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic set_pilots(input int vi, input int vq);
        for (int k = 0; k < 4; k++) begin
            pil_i[k] = vi;
            pil_q[k] = vq;
        end
    endtask

    // Pilots pre-multiplied by p_n*base so the corrected pilots are all (+64, 0).
    task automatic set_pilots_corrected(input int n);
        for (int k = 0; k < 4; k++) begin
            pil_i[k] = pn(n) * base_of(k) * 64;
            pil_q[k] = 0;
        end
    endtask

    task automatic send_symbol(input int seed, input int gap, input logic first,
                               input logic fs, input int nsamp);
        int slot;
        int vi;
        int vq;
        for (int idx = 0; idx < nsamp; idx++) begin
            slot = pilot_slot(idx);
            if (slot >= 0) begin
                vi = pil_i[slot];
                vq = pil_q[slot];
            end else begin
                vi = seed + idx;
                vq = -(seed + 2 * idx);
                exp_i.push_back(vi);
                exp_q.push_back(vq);
            end
            cycle(1'b1, (idx == 0) ? first : 1'b0, (idx == 0) ? fs : 1'b0, W'(vi), W'(vq));
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_first    = 1'b0;
        bus.frame_start = 1'b0;
        bus.in_i        = '0;
        bus.in_q        = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_i !== '0) begin n_fail++; $display("FAIL rst_out_i: got %0d expected 0", bus.out_i); end
        n_checks++; if (bus.out_q !== '0) begin n_fail++; $display("FAIL rst_out_q: got %0d expected 0", bus.out_q); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b expected 0", bus.out_last); end
        n_checks++; if (bus.pilot_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pilot_valid: got %b expected 0", bus.pilot_valid); end
        n_checks++; if (bus.pilot_sum_i !== '0) begin n_fail++; $display("FAIL rst_sum_i: got %0d expected 0", bus.pilot_sum_i); end
        n_checks++; if (bus.pilot_sum_q !== '0) begin n_fail++; $display("FAIL rst_sum_q: got %0d expected 0", bus.pilot_sum_q); end
        n_checks++; if (bus.sym_index !== 7'd0) begin n_fail++; $display("FAIL rst_sym_index: got %0d expected 0", bus.sym_index); end
        n_checks++; if (bus.sym_err !== 1'b0) begin n_fail++; $display("FAIL rst_sym_err: got %b expected 0", bus.sym_err); end
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.pilot_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle_valid: got %b/%b expected 0/0", bus.out_valid, bus.pilot_valid);
        end
    endtask

    task automatic test_single_symbol();
        int db, eb, n;
        db = got_i.size(); eb = ev_i.size();
        exp_i.delete(); exp_q.delete();
        set_pilots(100, -50);
        send_symbol(10, 0, 1'b1, 1'b1, 52);
        idle(3);
        n = got_i.size() - db;
        n_checks++; if (n != 48) begin n_fail++; $display("FAIL t1_data_count: got %0d expected 48", n); end
        for (int j = 0; j < 48 && j < n; j++) begin
            n_checks++;
            if (got_i[db+j] !== exp_i[j] || got_q[db+j] !== exp_q[j] || got_last[db+j] !== ((j == 47) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL t1_data[%0d]: got (%0d,%0d,last %0d) expected (%0d,%0d,last %0d)",
                         j, got_i[db+j], got_q[db+j], got_last[db+j], exp_i[j], exp_q[j], (j == 47) ? 1 : 0);
            end
        end
        n = ev_i.size() - eb;
        n_checks++; if (n != 1) begin n_fail++; $display("FAIL t1_event_count: got %0d expected 1", n); end
        if (n >= 1) begin
            n_checks++; if (ev_i[eb] !== 200) begin n_fail++; $display("FAIL t1_sum_i: got %0d expected 200", ev_i[eb]); end
            n_checks++; if (ev_q[eb] !== -100) begin n_fail++; $display("FAIL t1_sum_q: got %0d expected -100", ev_q[eb]); end
            n_checks++; if (ev_idx[eb] !== 0) begin n_fail++; $display("FAIL t1_sym_index: got %0d expected 0", ev_idx[eb]); end
        end
        idle(4);
        n_checks++; if (bus.pilot_sum_i !== 15'sd200) begin n_fail++; $display("FAIL t1_sum_hold: got %0d expected 200", bus.pilot_sum_i); end
    endtask

    task automatic test_polarity_period();
        int db, eb, n;
        db = got_i.size(); eb = ev_i.size();
        for (int s = 0; s < 128; s++) begin
            set_pilots_corrected(s);
            send_symbol(s % 200, 0, 1'b0, (s == 0) ? 1'b1 : 1'b0, 52);
        end
        idle(3);
        n = got_i.size() - db;
        n_checks++; if (n != 128 * 48) begin n_fail++; $display("FAIL t2_data_count: got %0d expected %0d", n, 128 * 48); end
        n = ev_i.size() - eb;
        n_checks++; if (n != 128) begin n_fail++; $display("FAIL t2_event_count: got %0d expected 128", n); end
        for (int s = 0; s < 128 && s < n; s++) begin
            n_checks++;
            if (ev_i[eb+s] !== 256 || ev_q[eb+s] !== 0 || ev_idx[eb+s] !== ((s == 127) ? 0 : s)) begin
                n_fail++;
                $display("FAIL t2_symbol[%0d]: got (%0d,%0d,idx %0d) expected (256,0,idx %0d)",
                         s, ev_i[eb+s], ev_q[eb+s], ev_idx[eb+s], (s == 127) ? 0 : s);
            end
        end
    endtask

    task automatic test_extreme_negation();
        int eb, n;
        eb = ev_i.size();
        set_pilots(0, 0);
        for (int s = 0; s < 4; s++) send_symbol(20, 0, 1'b1, (s == 0) ? 1'b1 : 1'b0, 52);
        set_pilots(-2048, -2048);
        send_symbol(30, 0, 1'b1, 1'b0, 52);
        idle(3);
        n = ev_i.size() - eb;
        n_checks++; if (n != 5) begin n_fail++; $display("FAIL t3_event_count: got %0d expected 5", n); end
        if (n >= 5) begin
            n_checks++; if (ev_i[eb+4] !== 4096) begin n_fail++; $display("FAIL t3_sum_i: got %0d expected 4096", ev_i[eb+4]); end
            n_checks++; if (ev_q[eb+4] !== 4096) begin n_fail++; $display("FAIL t3_sum_q: got %0d expected 4096", ev_q[eb+4]); end
            n_checks++; if (ev_idx[eb+4] !== 4) begin n_fail++; $display("FAIL t3_sym_index: got %0d expected 4", ev_idx[eb+4]); end
        end
    endtask

    task automatic test_early_first();
        int eb, n, e0;
        eb = ev_i.size(); e0 = err_pulses;
        for (int s = 0; s < 3; s++) begin
            set_pilots_corrected(s);
            send_symbol(40, 0, 1'b1, (s == 0) ? 1'b1 : 1'b0, 52);
        end
        set_pilots(700, 700);
        send_symbol(50, 0, 1'b1, 1'b0, 30);
        set_pilots_corrected(3);
        send_symbol(60, 0, 1'b1, 1'b0, 52);
        idle(3);
        n = err_pulses - e0;
        n_checks++; if (n != 1) begin n_fail++; $display("FAIL t4_sym_err_pulses: got %0d expected 1", n); end
        n = ev_i.size() - eb;
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL t4_event_count: got %0d expected 4", n); end
        if (n >= 4) begin
            n_checks++; if (ev_i[eb+3] !== 256) begin n_fail++; $display("FAIL t4_sum_i: got %0d expected 256", ev_i[eb+3]); end
            n_checks++; if (ev_q[eb+3] !== 0) begin n_fail++; $display("FAIL t4_sum_q: got %0d expected 0", ev_q[eb+3]); end
            n_checks++; if (ev_idx[eb+3] !== 3) begin n_fail++; $display("FAIL t4_sym_index: got %0d expected 3", ev_idx[eb+3]); end
        end
    endtask

    task automatic test_gaps();
        int db, eb, n;
        db = got_i.size(); eb = ev_i.size();
        exp_i.delete(); exp_q.delete();
        set_pilots(100, -50);
        send_symbol(300, 2, 1'b1, 1'b1, 52);
        idle(3);
        n = got_i.size() - db;
        n_checks++; if (n != 48) begin n_fail++; $display("FAIL t5_data_count: got %0d expected 48", n); end
        for (int j = 0; j < 48 && j < n; j++) begin
            n_checks++;
            if (got_i[db+j] !== exp_i[j] || got_q[db+j] !== exp_q[j] || got_last[db+j] !== ((j == 47) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL t5_data[%0d]: got (%0d,%0d,last %0d) expected (%0d,%0d,last %0d)",
                         j, got_i[db+j], got_q[db+j], got_last[db+j], exp_i[j], exp_q[j], (j == 47) ? 1 : 0);
            end
        end
        n = ev_i.size() - eb;
        n_checks++; if (n != 1) begin n_fail++; $display("FAIL t5_event_count: got %0d expected 1", n); end
        if (n >= 1) begin
            n_checks++; if (ev_i[eb] !== 200 || ev_q[eb] !== -100 || ev_idx[eb] !== 0) begin
                n_fail++; $display("FAIL t5_sums: got (%0d,%0d,idx %0d) expected (200,-100,idx 0)", ev_i[eb], ev_q[eb], ev_idx[eb]);
            end
        end
    endtask

    task automatic test_reset_mid_symbol();
        int eb, n;
        set_pilots(500, 500);
        send_symbol(70, 0, 1'b1, 1'b1, 20);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        #1;
        n_checks++; if (bus.pilot_sum_i !== '0 || bus.pilot_sum_q !== '0) begin
            n_fail++; $display("FAIL t6_sums_in_reset: got (%0d,%0d) expected (0,0)", bus.pilot_sum_i, bus.pilot_sum_q);
        end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_i !== '0) begin
            n_fail++; $display("FAIL t6_out_in_reset: got (%b,%0d) expected (0,0)", bus.out_valid, bus.out_i);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        eb = ev_i.size();
        set_pilots(100, -50);
        send_symbol(80, 0, 1'b1, 1'b1, 52);
        idle(3);
        n = ev_i.size() - eb;
        n_checks++; if (n != 1) begin n_fail++; $display("FAIL t6_event_count: got %0d expected 1", n); end
        if (n >= 1) begin
            n_checks++; if (ev_i[eb] !== 200 || ev_q[eb] !== -100 || ev_idx[eb] !== 0) begin
                n_fail++; $display("FAIL t6_sums: got (%0d,%0d,idx %0d) expected (200,-100,idx 0)", ev_i[eb], ev_q[eb], ev_idx[eb]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_polarity_period();
        test_extreme_negation();
        test_early_first();
        test_gaps();
        test_reset_mid_symbol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
